// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
//            Optional single-cycle multiply via `define MULDIV_FAST_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic [1:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             hiwriteE,
    input  logic             lowriteE,
    input  logic [WIDTH-1:0] hilowdataE,
    output logic             mdrunE,
    output logic             mddoneE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   srca_q, srca_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    // Operand magnitudes; only signed ops (mdopE[0]==0) negate.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = ~mdopE[0] & srcaE[WIDTH-1];
    assign b_neg = ~mdopE[0] & srcbE[WIDTH-1];
    assign a_mag = a_neg ? -srcaE : srcaE;
    assign b_mag = b_neg ? -srcbE : srcbE;

    // Multiply step: multiplier sits in acc low half, partial product high.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: remainder in acc high half, dividend shifts out / quotient in.
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    assign div_ok    = ~div_trial[WIDTH];
    assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        srca_d    = srca_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hiwriteE) hi_d = hilowdataE;
                if (lowriteE) lo_d = hilowdataE;
                if (mdstartE && !flushE) begin
                    is_div_d  = mdopE[1];
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = mdopE[1] && (srcbE == '0);
                    srca_d    = srcaE;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    if (mdopE[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        state_d = ST_RUN;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = fast_prod;
                        state_d = ST_FIX;
`else
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opb_d   = a_mag;
                        state_d = ST_RUN;
`endif
                    end
                end
            end
            ST_RUN: begin
                if (flushE) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) state_d = ST_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flushE) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (dbz_q) begin
                        hi_d = srca_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            srca_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            srca_q    <= srca_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign mdrunE  = (state_q != ST_IDLE);
    assign mddoneE = done_q;
    assign hiE     = hi_q;
    assign loE     = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Directed self-checking bench for muldiv_seq (MULDIV_FAST_MUL_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int EXP_MUL = 1;
`else
    localparam int EXP_MUL = 33;
`endif
    localparam int EXP_DIV = 33;

    logic         clk = 1'b0;
    logic         reset;
    logic         mdstartE;
    logic [1:0]   mdopE;
    logic [W-1:0] srcaE, srcbE;
    logic         flushE, hiwriteE, lowriteE;
    logic [W-1:0] hilowdataE;
    logic         mdrunE, mddoneE;
    logic [W-1:0] hiE, loE;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat, runs, dones;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mdstartE   (mdstartE),
        .mdopE      (mdopE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .flushE     (flushE),
        .hiwriteE   (hiwriteE),
        .lowriteE   (lowriteE),
        .hilowdataE (hilowdataE),
        .mdrunE     (mdrunE),
        .mddoneE    (mddoneE),
        .hiE        (hiE),
        .loE        (loE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        mdopE    = op;
        srcaE    = a;
        srcbE    = b;
        mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
    endtask

    // Ticks from just after the accept edge until mddoneE is seen.
    task automatic wait_done(output int ticks, output int nrun);
        ticks = 0;
        nrun  = 0;
        while (mddoneE !== 1'b1 && ticks < 100) begin
            if (mdrunE === 1'b1) nrun++;
            tick();
            ticks++;
        end
        check("done_seen", {63'd0, mddoneE}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; mdstartE = 1'b0; mdopE = 2'b00; srcaE = '0; srcbE = '0;
        flushE = 1'b0; hiwriteE = 1'b0; lowriteE = 1'b0; hilowdataE = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_hi",   hiE, 64'd0);
        check("rst_lo",   loE, 64'd0);
        check("rst_run",  mdrunE, 64'd0);
        check("rst_done", mddoneE, 64'd0);

        // MTLO / MTHI in IDLE
        lowriteE = 1'b1; hilowdataE = 32'h0000_1234;
        tick();
        lowriteE = 1'b0;
        check("mtlo_idle", loE, 64'h1234);
        hiwriteE = 1'b1; hilowdataE = 32'h0000_5678;
        tick();
        hiwriteE = 1'b0;
        check("mthi_idle", hiE, 64'h5678);

        // MULTU max x max, with latency and busy count
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, runs);
        check("multu_lat",  lat, EXP_MUL);
        check("multu_runs", runs, EXP_MUL);
        check("multu_run0", mdrunE, 64'd0);
        check("multu_hi",   hiE, 64'hFFFF_FFFE);
        check("multu_lo",   loE, 64'h0000_0001);
        tick();
        check("done_pulse", mddoneE, 64'd0);

        // MULT -3 x 7
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, runs);
        check("mult_hi", hiE, 64'hFFFF_FFFF);
        check("mult_lo", loE, 64'hFFFF_FFEB);

        // DIV -7 / 2
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, runs);
        check("div_lat", lat, EXP_DIV);
        check("div_hi",  hiE, 64'hFFFF_FFFF);
        check("div_lo",  loE, 64'hFFFF_FFFD);

        // DIVU 100 / 7 started back-to-back in the mddoneE cycle
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(lat, runs);
        check("b2b_lat", lat, EXP_DIV);
        check("divu_hi", hiE, 64'd2);
        check("divu_lo", loE, 64'd14);

        // DIVU 5 / 0
        start_op(2'b11, 32'd5, 32'd0);
        wait_done(lat, runs);
        check("dbz_lat", lat, EXP_DIV);
        check("dbz_hi",  hiE, 64'd5);
        check("dbz_lo",  loE, 64'hFFFF_FFFF);

        // Signed DIV by zero with negative dividend
        start_op(2'b10, 32'hFFFF_FFF0, 32'd0);
        wait_done(lat, runs);
        check("sdbz_hi", hiE, 64'hFFFF_FFF0);
        check("sdbz_lo", loE, 64'hFFFF_FFFF);

        // DIV 0x80000000 / -1
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, runs);
        check("ovf_hi", hiE, 64'd0);
        check("ovf_lo", loE, 64'h8000_0000);
        tick();

        // Flush at cycle 10 of a DIVU
        start_op(2'b11, 32'd100, 32'd7);
        repeat (9) tick();
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        check("flush_run", mdrunE, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (mddoneE === 1'b1) dones++;
            tick();
        end
        check("flush_nodone", dones, 64'd0);
        check("flush_hi", hiE, 64'd0);
        check("flush_lo", loE, 64'h8000_0000);

        // Flush in IDLE blocks a same-cycle start
        flushE = 1'b1; mdopE = 2'b11; srcaE = 32'd9; srcbE = 32'd3; mdstartE = 1'b1;
        tick();
        flushE = 1'b0; mdstartE = 1'b0;
        check("flush_idle_run", mdrunE, 64'd0);

        // MTLO while busy is ignored
        start_op(2'b11, 32'd9, 32'd3);
        lowriteE = 1'b1; hilowdataE = 32'h0000_DEAD;
        tick();
        lowriteE = 1'b0;
        check("mtlo_busy", loE, 64'h8000_0000);
        wait_done(lat, runs);
        check("busy_op_hi", hiE, 64'd0);
        check("busy_op_lo", loE, 64'd3);

        // mdstartE while busy is ignored
        start_op(2'b11, 32'd100, 32'd7);
        repeat (3) tick();
        mdopE = 2'b01; srcaE = 32'd9; srcbE = 32'd3; mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
        wait_done(lat, runs);
        check("ign_lat", lat + 4, EXP_DIV);
        check("ign_hi",  hiE, 64'd2);
        check("ign_lo",  loE, 64'd14);

        // Reset in cycle 20 of a run
        start_op(2'b11, 32'd1000, 32'd3);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_hi",   hiE, 64'd0);
        check("mrst_lo",   loE, 64'd0);
        check("mrst_run",  mdrunE, 64'd0);
        check("mrst_done", mddoneE, 64'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (mddoneE === 1'b1) dones++;
            tick();
        end
        check("mrst_nodone", dones, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
